// File: rtl/soc_system_clken_pkg.sv
// Shared types and helpers for the fractional clock-enable generator:
// lock FSM states, channel-index width and config-request validation.
package soc_system_clken_pkg;

   typedef enum logic [1:0] {
      ST_LOCKING = 2'd0,
      ST_LOCKED  = 2'd1,
      ST_APPLY   = 2'd2
   } state_e;

   function automatic int chan_w(input int n_clocks);
      return (n_clocks > 1) ? $clog2(n_clocks) : 1;
   endfunction

   // A request is usable only if 0 < num <= den and it addresses a real channel.
   function automatic logic cfg_ok(input logic [31:0] chan,
                                   input logic [31:0] num,
                                   input logic [31:0] den,
                                   input int          n_clocks);
      return (den != '0) && (num != '0) && (num <= den) && (chan < 32'(n_clocks));
   endfunction

endpackage

// File: rtl/soc_system_clken_nco.sv
// One fractional-rate channel: phase accumulator emitting num pulses per den
// refclk cycles, plus a toggle output flipping on every pulse.
module soc_system_clken_nco
   import soc_system_clken_pkg::*;
#(
   parameter int ACC_W    = 16,
   parameter int INIT_NUM = 1,
   parameter int INIT_DEN = 2
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [ACC_W-1:0] num_i,
   input  logic [ACC_W-1:0] den_i,
   output logic             en_o,
   output logic             tgl_o
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] num_q, den_q;
   logic             en_q, en_d;
   logic             tgl_q, tgl_d;
   logic [ACC_W:0]   sum;

   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      sum   = {1'b0, acc_q} + {1'b0, num_q};
      acc_d = acc_q;
      en_d  = 1'b0;
      tgl_d = tgl_q;
      if (sum >= {1'b0, den_q}) begin
         acc_d = ACC_W'(sum - {1'b0, den_q});
         en_d  = 1'b1;
         tgl_d = ~tgl_q;
      end else begin
         acc_d = sum[ACC_W-1:0];
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge refclk) begin
      if (rst) begin
         acc_q <= '0;
         num_q <= ACC_W'(INIT_NUM);
         den_q <= ACC_W'(INIT_DEN);
         en_q  <= 1'b0;
         tgl_q <= 1'b0;
      end else if (load_i) begin
         // Reprogramming restarts the phase from zero, exactly like reset.
         acc_q <= '0;
         num_q <= num_i;
         den_q <= den_i;
         en_q  <= 1'b0;
         tgl_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         en_q  <= en_d;
         tgl_q <= tgl_d;
      end
   end

   assign en_o  = en_q;
   assign tgl_o = tgl_q;

endmodule

// File: rtl/soc_system_clken_gen.sv
// Multi-channel fractional clock-enable generator: config handshake, lock
// qualification FSM and one NCO per output channel, all on refclk.
module soc_system_clken_gen
   import soc_system_clken_pkg::*;
#(
   parameter  int NUM_CLOCKS  = 2,
   parameter  int ACC_W       = 16,
   parameter  int LOCK_CYCLES = 256,
   parameter  int INIT_NUM    = 1,
   parameter  int INIT_DEN    = 2,
   localparam int CH_W        = chan_w(NUM_CLOCKS)
) (
   input  logic                  refclk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [CH_W-1:0]       cfg_chan,
   input  logic [ACC_W-1:0]      cfg_num,
   input  logic [ACC_W-1:0]      cfg_den,
   output logic                  cfg_err,
   output logic [NUM_CLOCKS-1:0] outclk_en,
   output logic [NUM_CLOCKS-1:0] outclk_tgl,
   output logic                  locked
);

   localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             locked_q, locked_d;
   logic             ready_q, ready_d;
   logic             err_q, err_d;
   logic             req_ok;
   logic             xfer_ok;

   assign req_ok  = cfg_ok(32'(cfg_chan), 32'(cfg_num), 32'(cfg_den), NUM_CLOCKS);
   assign xfer_ok = cfg_valid && ready_q && req_ok;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      locked_d = locked_q;
      err_d    = cfg_valid && ready_q && !req_ok;
      unique case (state_q)
         ST_LOCKING: begin
            if (xfer_ok) begin
               state_d  = ST_APPLY;
               cnt_d    = '0;
               locked_d = 1'b0;
            end else if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
               state_d  = ST_LOCKED;
               cnt_d    = cnt_q + CNT_W'(1);
               locked_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_LOCKED: begin
            if (xfer_ok) begin
               state_d  = ST_APPLY;
               cnt_d    = '0;
               locked_d = 1'b0;
            end
         end
         ST_APPLY: begin
            state_d  = ST_LOCKING;
            cnt_d    = '0;
            locked_d = 1'b0;
         end
         default: begin
            state_d  = ST_LOCKING;
            cnt_d    = '0;
            locked_d = 1'b0;
         end
      endcase
      // Ready is registered so the port is stalled for the whole APPLY cycle.
      ready_d = (state_d != ST_APPLY);
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q  <= ST_LOCKING;
         cnt_q    <= '0;
         locked_q <= 1'b0;
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         locked_q <= locked_d;
         ready_q  <= ready_d;
         err_q    <= err_d;
      end
   end

   assign cfg_ready = ready_q;
   assign cfg_err   = err_q;
   assign locked    = locked_q;

   for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_nco
      logic load;
      assign load = xfer_ok && (cfg_chan == CH_W'(g));

      soc_system_clken_nco #(
         .ACC_W    (ACC_W),
         .INIT_NUM (INIT_NUM),
         .INIT_DEN (INIT_DEN)
      ) u_nco (
         .refclk (refclk),
         .rst    (rst),
         .load_i (load),
         .num_i  (cfg_num),
         .den_i  (cfg_den),
         .en_o   (outclk_en[g]),
         .tgl_o  (outclk_tgl[g])
      );
   end

endmodule

// File: tb/tb_soc_system_clken_gen.sv
// Self-checking bench: per-cycle arithmetic reference model of every output,
// table-driven config writes and hand-written lock/reset sequences.
module tb_soc_system_clken_gen;

   localparam int NCLK = 3;
   localparam int AW   = 16;
   localparam int LC   = 256;

   logic            refclk;
   logic            rst;
   logic            cfg_valid;
   logic            cfg_ready;
   logic [1:0]      cfg_chan;
   logic [AW-1:0]   cfg_num;
   logic [AW-1:0]   cfg_den;
   logic            cfg_err;
   logic [NCLK-1:0] outclk_en;
   logic [NCLK-1:0] outclk_tgl;
   logic            locked;

   int n_tests = 0;
   int n_fail  = 0;

   soc_system_clken_gen #(
      .NUM_CLOCKS  (NCLK),
      .ACC_W       (AW),
      .LOCK_CYCLES (LC),
      .INIT_NUM    (1),
      .INIT_DEN    (2)
   ) dut (
      .refclk     (refclk),
      .rst        (rst),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_chan   (cfg_chan),
      .cfg_num    (cfg_num),
      .cfg_den    (cfg_den),
      .cfg_err    (cfg_err),
      .outclk_en  (outclk_en),
      .outclk_tgl (outclk_tgl),
      .locked     (locked)
   );

   initial begin
      refclk = 1'b0;
      forever #5 refclk = ~refclk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Pulses emitted by a num/den channel in its first k cycles after (re)start.
   function automatic longint pulses(input longint k, input longint n, input longint d);
      return (k * n) / d;
   endfunction

   // Reference model: derived from edge counts and ratios, sampled at each posedge.
   longint edge_no = 0;
   longint base    = 0;
   bit     m_init  = 1'b0;
   bit     m_ready = 1'b0;
   bit     m_err   = 1'b0;
   bit     m_lock  = 1'b0;
   longint m_n [NCLK];
   longint m_d [NCLK];
   longint m_k [NCLK];
   int     rdy_low_cnt = 0;

   logic            s_rst, s_v, s_xfer, s_ok;
   logic [1:0]      s_ch;
   longint          s_n, s_d;
   logic [NCLK-1:0] exp_en, exp_tgl;

   always @(posedge refclk) begin
      s_rst = rst;
      s_v   = cfg_valid;
      s_ch  = cfg_chan;
      s_n   = longint'(cfg_num);
      s_d   = longint'(cfg_den);
      edge_no++;
      if (s_rst) begin
         m_init = 1'b1;
         base   = edge_no;
         for (int c = 0; c < NCLK; c++) begin
            m_n[c] = 1;
            m_d[c] = 2;
            m_k[c] = 0;
         end
         m_ready = 1'b0;
         m_err   = 1'b0;
         m_lock  = 1'b0;
      end else if (m_init) begin
         s_xfer = s_v && m_ready;
         s_ok   = (s_d != 0) && (s_n != 0) && (s_n <= s_d) && (int'(s_ch) < NCLK);
         m_err  = s_xfer && !s_ok;
         for (int c = 0; c < NCLK; c++) begin
            if (s_xfer && s_ok && int'(s_ch) == c) begin
               m_n[c] = s_n;
               m_d[c] = s_d;
               m_k[c] = 0;
            end else begin
               m_k[c] = m_k[c] + 1;
            end
         end
         if (s_xfer && s_ok) base = edge_no + 1;
         m_lock  = (edge_no - base) >= LC;
         m_ready = !(s_xfer && s_ok);
      end
      #1;
      if (m_init) begin
         for (int c = 0; c < NCLK; c++) begin
            exp_en[c]  = (m_k[c] != 0) &&
                         (pulses(m_k[c], m_n[c], m_d[c]) != pulses(m_k[c] - 1, m_n[c], m_d[c]));
            exp_tgl[c] = (pulses(m_k[c], m_n[c], m_d[c]) % 2) != 0;
         end
         check("model_outclk_en", 64'(outclk_en), 64'(exp_en));
         check("model_outclk_tgl", 64'(outclk_tgl), 64'(exp_tgl));
         check("model_locked", 64'(locked), 64'(m_lock));
         check("model_cfg_ready", 64'(cfg_ready), 64'(m_ready));
         check("model_cfg_err", 64'(cfg_err), 64'(m_err));
         if (!cfg_ready) rdy_low_cnt++;
      end
   end

   // Called at a negedge; returns at the negedge right after the transfer edge.
   task automatic do_write(input int ch, input int n, input int d);
      int tries = 0;
      cfg_valid = 1'b1;
      cfg_chan  = 2'(ch);
      cfg_num   = AW'(n);
      cfg_den   = AW'(d);
      while (!cfg_ready && tries < 20) begin
         @(negedge refclk);
         tries++;
      end
      check("write_accepted", 64'(tries < 20), 64'(1));
      @(negedge refclk);
      cfg_valid = 1'b0;
   endtask

   typedef struct {
      int   chan;
      int   num;
      int   den;
      logic exp_err;
      logic exp_locked;
   } wr_vec_t;

   wr_vec_t vecs [5];

   initial begin
      int          cnt;
      int          bad;
      int          pcount;
      int          low;
      logic [7:0]  en_bits, tgl_bits;
      logic        en_hist [700];

      vecs[0] = '{chan: 0, num: 1, den: 0, exp_err: 1'b1, exp_locked: 1'b1};
      vecs[1] = '{chan: 1, num: 5, den: 4, exp_err: 1'b1, exp_locked: 1'b1};
      vecs[2] = '{chan: 0, num: 0, den: 3, exp_err: 1'b1, exp_locked: 1'b1};
      vecs[3] = '{chan: 3, num: 1, den: 2, exp_err: 1'b1, exp_locked: 1'b1};
      vecs[4] = '{chan: 0, num: 2, den: 5, exp_err: 1'b0, exp_locked: 1'b0};

      rst       = 1'b1;
      cfg_valid = 1'b0;
      cfg_chan  = '0;
      cfg_num   = '0;
      cfg_den   = '0;
      repeat (3) @(negedge refclk);
      check("reset_en", 64'(outclk_en), 64'(0));
      check("reset_tgl", 64'(outclk_tgl), 64'(0));
      check("reset_locked", 64'(locked), 64'(0));
      check("reset_ready", 64'(cfg_ready), 64'(0));
      check("reset_err", 64'(cfg_err), 64'(0));

      // Release: default 1/2 pattern and lock latency.
      rst = 1'b0;
      cnt = 0;
      en_bits = '0;
      tgl_bits = '0;
      while (cnt < 1000) begin
         @(negedge refclk);
         cnt++;
         if (cnt <= 8) begin
            en_bits[cnt-1]  = outclk_en[0];
            tgl_bits[cnt-1] = outclk_tgl[0];
         end
         if (locked) break;
      end
      check("release_en_pattern", 64'(en_bits), 64'(8'hAA));
      check("release_tgl_pattern", 64'(tgl_bits), 64'(8'h66));
      check("release_lock_latency", 64'(cnt), 64'(LC));

      // ch1 = 3/7: three pulses in every 7-cycle window, relock after 257 cycles.
      do_write(1, 3, 7);
      low = locked ? 0 : 1;
      for (int i = 0; i < 700; i++) begin
         @(negedge refclk);
         en_hist[i] = outclk_en[1];
         if (!locked) low++;
      end
      bad = 0;
      pcount = 0;
      for (int i = 0; i < 700; i++) pcount += int'(en_hist[i]);
      for (int s = 0; s + 7 <= 700; s++) begin
         cnt = 0;
         for (int j = 0; j < 7; j++) cnt += int'(en_hist[s+j]);
         if (cnt != 3) bad++;
      end
      check("ratio_3_7_windows", 64'(bad), 64'(0));
      check("ratio_3_7_total", 64'(pcount), 64'(300));
      check("ratio_3_7_lock_low", 64'(low), 64'(LC + 1));

      // Invalid requests are discarded with a one-cycle error; a valid one relocks.
      foreach (vecs[i]) begin
         do_write(vecs[i].chan, vecs[i].num, vecs[i].den);
         check("vec_cfg_err", 64'(cfg_err), 64'(vecs[i].exp_err));
         check("vec_locked", 64'(locked), 64'(vecs[i].exp_locked));
         @(negedge refclk);
         check("vec_err_one_cycle", 64'(cfg_err), 64'(0));
      end
      cnt = 0;
      while (!locked && cnt < 400) begin
         @(negedge refclk);
         cnt++;
      end
      check("relock_after_vec", 64'(locked), 64'(1));

      // Full-scale ratios on ch2.
      do_write(2, 65535, 65535);
      pcount = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge refclk);
         pcount += int'(outclk_en[2]);
      end
      check("full_rate_pulses", 64'(pcount), 64'(50));
      do_write(2, 65534, 65535);
      pcount = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge refclk);
         pcount += int'(outclk_en[2]);
      end
      check("near_full_no_overflow", 64'(pcount), 64'(99));
      do_write(2, 1, 65535);
      pcount = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge refclk);
         pcount += int'(outclk_en[2]);
      end
      check("min_rate_pulses", 64'(pcount), 64'(0));

      // Second valid write during LOCKING restarts the lock count.
      rdy_low_cnt = 0;
      do_write(0, 1, 3);
      repeat (99) @(negedge refclk);
      do_write(0, 2, 3);
      cnt = 0;
      while (cnt < 1000) begin
         @(negedge refclk);
         cnt++;
         if (locked) break;
      end
      check("relock_after_second_write", 64'(cnt), 64'(LC + 1));
      check("ready_low_only_apply", 64'(rdy_low_cnt), 64'(2));

      // Reset while LOCKED with a request pending.
      cfg_valid = 1'b1;
      cfg_chan  = 2'd1;
      cfg_num   = AW'(1);
      cfg_den   = AW'(1);
      rst       = 1'b1;
      @(negedge refclk);
      check("midrst_en", 64'(outclk_en), 64'(0));
      check("midrst_tgl", 64'(outclk_tgl), 64'(0));
      check("midrst_locked", 64'(locked), 64'(0));
      check("midrst_ready", 64'(cfg_ready), 64'(0));
      repeat (2) @(negedge refclk);
      rst       = 1'b0;
      cfg_valid = 1'b0;
      en_bits   = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge refclk);
         en_bits[i] = outclk_en[1];
      end
      check("midrst_defaults_ch1", 64'(en_bits), 64'(8'hAA));

      // Random mix of valid and invalid requests, checked by the model.
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 20)) @(negedge refclk);
         do_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
                  int'($urandom_range(0, 12)));
      end
      repeat (30) @(negedge refclk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
